// File: rtl/mcu_timer.sv
// mcu_timer: six-register timer/counter with prescaler, up/down, one-shot,
// terminal-count interrupt flag and compare-driven PWM.
module mcu_timer #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq,
    output logic             pwm_out
);
    logic [3:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d, psc_q, psc_d;
    logic [WIDTH-1:0]   top_q, top_d, cmp_q, cmp_d, count_q, count_d;
    logic               flag_q, flag_d;
    logic               en, dir, oneshot, tick, term;
    logic               wr_ctrl, wr_presc, wr_top, wr_cmp, wr_count, wr_status;

    assign en        = ctrl_q[0];
    assign dir       = ctrl_q[1];
    assign oneshot   = ctrl_q[2];
    assign wr_ctrl   = wr_en && addr == 3'd0;
    assign wr_presc  = wr_en && addr == 3'd1;
    assign wr_top    = wr_en && addr == 3'd2;
    assign wr_cmp    = wr_en && addr == 3'd3;
    assign wr_count  = wr_en && addr == 3'd4;
    assign wr_status = wr_en && addr == 3'd5;
    assign tick      = en && psc_q == presc_q;
    assign term      = tick && (dir ? count_q == '0 : count_q == top_q);
    assign irq       = flag_q & ctrl_q[3];
    assign pwm_out   = en & (count_q < cmp_q);

    always_comb begin
        ctrl_d  = wr_ctrl ? wdata[3:0] : (term && oneshot) ? {ctrl_q[3:1], 1'b0} : ctrl_q;
        presc_d = wr_presc ? wdata[PRESC_W-1:0] : presc_q;
        top_d   = wr_top ? wdata : top_q;
        cmp_d   = wr_cmp ? wdata : cmp_q;
        count_d = wr_count ? wdata :
                  !tick    ? count_q :
                  term     ? (dir ? top_q : '0) :
                  dir      ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
        // Prescaler restarts from 0 whenever counting (re)starts or COUNT is loaded.
        psc_d   = (wr_count || !en || !ctrl_d[0] || tick) ? '0 : psc_q + PRESC_W'(1);
        flag_d  = term || (flag_q && !(wr_status && wdata[0]));
    end

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0: rdata = WIDTH'(ctrl_q);
            3'd1: rdata = WIDTH'(presc_q);
            3'd2: rdata = top_q;
            3'd3: rdata = cmp_q;
            3'd4: rdata = count_q;
            3'd5: rdata = WIDTH'(flag_q);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            psc_q   <= '0;
            top_q   <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            psc_q   <= psc_d;
            top_q   <= top_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_mcu_timer.sv
// tb_mcu_timer: directed register-level checks of mcu_timer with hand-computed
// expectations for reset, counting modes, PWM and write/tick collisions.
module tb_mcu_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        irq, pwm_out;
    int          nvec = 0;
    int          nerr = 0;
    int          hc;

    mcu_timer #(.WIDTH(16), .PRESC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string tag);
        addr = a;
        #1 chk(tag, rdata, e);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset state
        #12;
        rd(3'd0, 16'h0000, "rst_ctrl");
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_pwm", {15'd0, pwm_out}, 16'd0);
        rd(3'd4, 16'h0000, "rst_count");
        @(negedge clk) rst_n = 1'b1;

        // Register map readback
        wr(3'd1, 16'hFFFF); wr(3'd2, 16'hFFFF); wr(3'd3, 16'hFFFF);
        wr(3'd4, 16'hFFFF); wr(3'd6, 16'hFFFF); wr(3'd7, 16'hFFFF);
        wr(3'd0, 16'hFFFF);
        rd(3'd0, 16'h000F, "map_ctrl");
        rd(3'd1, 16'h00FF, "map_presc");
        rd(3'd2, 16'hFFFF, "map_top");
        rd(3'd3, 16'hFFFF, "map_cmp");
        rd(3'd4, 16'hFFFF, "map_count");
        rd(3'd6, 16'h0000, "map_6");
        rd(3'd7, 16'h0000, "map_7");
        wr(3'd0, 16'h0000);

        // Asynchronous reset mid-count
        wr(3'd4, 16'h0005);
        wr(3'd0, 16'h0001);
        chk("pre_rst_pwm", {15'd0, pwm_out}, 16'd1);
        #2 rst_n = 1'b0;
        rd(3'd4, 16'h0000, "arst_count");
        rd(3'd5, 16'h0000, "arst_flag");
        chk("arst_irq", {15'd0, irq}, 16'd0);
        chk("arst_pwm", {15'd0, pwm_out}, 16'd0);
        rd(3'd0, 16'h0000, "arst_ctrl");
        @(negedge clk) rst_n = 1'b1;
        edges(3);
        rd(3'd4, 16'h0000, "post_rst_count");

        // Up periodic: PRESC=2, TOP=4, irq enabled
        wr(3'd1, 16'd2);
        wr(3'd2, 16'd4);
        wr(3'd0, 16'h0009);
        addr = 3'd4;
        for (int k = 1; k <= 5; k++) begin
            edges(3);
            chk($sformatf("up_count_%0d", k), rdata, 16'(k % 5));
            chk($sformatf("up_irq_%0d", k), {15'd0, irq}, (k == 5) ? 16'd1 : 16'd0);
        end
        wr(3'd0, 16'h0000);
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0000, "flag_clear");
        chk("irq_clear", {15'd0, irq}, 16'd0);

        // Down one-shot, irq disabled
        wr(3'd2, 16'd3);
        wr(3'd4, 16'd3);
        wr(3'd1, 16'd0);
        wr(3'd0, 16'h0007);
        addr = 3'd4;
        edges(1); chk("dn_2", rdata, 16'd2);
        edges(1); chk("dn_1", rdata, 16'd1);
        edges(1); chk("dn_0", rdata, 16'd0);
        edges(1); chk("dn_reload", rdata, 16'd3);
        rd(3'd0, 16'h0006, "os_ctrl");
        rd(3'd5, 16'h0001, "os_flag");
        chk("os_irq", {15'd0, irq}, 16'd0);
        edges(4);
        rd(3'd4, 16'd3, "os_hold");
        wr(3'd5, 16'h0001);

        // PWM: TOP=9, CMP=3, PRESC=0
        wr(3'd2, 16'd9);
        wr(3'd3, 16'd3);
        wr(3'd4, 16'd0);
        wr(3'd0, 16'h0001);
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            hc += int'(pwm_out);
            edges(1);
        end
        chk("pwm_cmp3", 16'(hc), 16'd6);
        wr(3'd3, 16'd0);
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            hc += int'(pwm_out);
            edges(1);
        end
        chk("pwm_cmp0", 16'(hc), 16'd0);
        wr(3'd3, 16'd12);
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            hc += int'(pwm_out);
            edges(1);
        end
        chk("pwm_cmp12", 16'(hc), 16'd20);

        // STATUS clear on terminal-event cycle: set wins
        wr(3'd0, 16'h0000);
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0000, "col_pre_flag");
        wr(3'd4, 16'd9);
        wr(3'd0, 16'h0001);
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0001, "col_flag");
        rd(3'd4, 16'h0000, "col_wrap");

        // COUNT write on tick cycle: write wins, prescaler restarts
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'd2);
        wr(3'd4, 16'd0);
        wr(3'd0, 16'h0001);
        edges(2);
        wr(3'd4, 16'd7);
        addr = 3'd4;
        #1 chk("cw_load", rdata, 16'd7);
        edges(2); chk("cw_hold", rdata, 16'd7);
        edges(1); chk("cw_next", rdata, 16'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
